// File: rtl/lsu_mem_ctrl_if.sv
// Data-memory request/grant/response channel between the load/store unit (master)
// and the data memory (slave).
interface lsu_mem_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Multi-cycle load/store unit: one request/grant/response transaction per access,
// aligned and sign-extended load return. Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module lsu_mem_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           valid_in,
    input  logic           load,
    input  logic           store,
    input  logic [7:0]     op_PMEM,
    input  logic [1:0]     op_load_sext,
    input  logic [31:0]    addr,
    input  logic [31:0]    wdata,
    output logic           stall,
    output logic [31:0]    rdata_out,
    output logic           rdata_valid,
    output logic           err,
    lsu_mem_ctrl_if.master mem
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       off_r;
    logic [3:0]       lanes_r;
    logic [1:0]       sext_r;
    logic             mem_req_r;
    logic             mem_we_r;
    logic [31:0]      mem_addr_r;
    logic [31:0]      mem_wdata_r;
    logic [3:0]       mem_wstrb_r;
    logic [31:0]      rdata_out_r;
    logic             rdata_valid_r;
    logic             err_r;

    logic [3:0]       lanes_s;
    logic [3:0]       strb_s;
    logic [31:0]      wdata_sh_s;
    logic             start_s;
    logic             misalign_s;
    logic [31:0]      load_fmt_s;
    logic             unused_s;

    // Expand a 4-bit lane mask into a 32-bit byte mask.
    function automatic logic [31:0] lane_expand(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    // Right-align, size-mask and optionally sign-extend the raw memory word.
    function automatic logic [31:0] fmt_load(input logic [31:0] raw, input logic [1:0] off,
                                             input logic [3:0] lanes, input logic [1:0] sext);
        logic [31:0] d;
        logic [31:0] r;
        d = (raw >> {off, 3'b000}) & lane_expand(lanes);
        case (sext)
            2'b01:   r = {{24{d[7]}}, d[7:0]};
            2'b10:   r = {{16{d[15]}}, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    // Request-side decode of the instruction currently presented.
    always_comb begin
        lanes_s    = op_PMEM[3:0];
        strb_s     = lanes_s << addr[1:0];
        wdata_sh_s = wdata << {addr[1:0], 3'b000};
        start_s    = valid_in & (load | store);
`ifdef LSU_MISALIGN_TRAP_EN
        misalign_s = ((lanes_s == 4'h3) & addr[0]) |
                     ((lanes_s == 4'hF) & (addr[1:0] != 2'b00));
`else
        misalign_s = 1'b0;
`endif
    end

    assign load_fmt_s = fmt_load(mem.mem_rdata, off_r, lanes_r, sext_r);
    assign unused_s   = ^op_PMEM[7:4];

    // Reset gates stall so the core is released the instant reset is applied.
    assign stall = ~rst & (((state_r == IDLE) & start_s) | (state_r == REQ) | (state_r == WAIT));

    // Access sequencer with registered memory-side and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            cnt_r         <= '0;
            off_r         <= 2'b00;
            lanes_r       <= 4'h0;
            sext_r        <= 2'b00;
            mem_req_r     <= 1'b0;
            mem_we_r      <= 1'b0;
            mem_addr_r    <= 32'h0000_0000;
            mem_wdata_r   <= 32'h0000_0000;
            mem_wstrb_r   <= 4'h0;
            rdata_out_r   <= 32'h0000_0000;
            rdata_valid_r <= 1'b0;
            err_r         <= 1'b0;
        end else begin
            rdata_valid_r <= 1'b0;
            err_r         <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start_s && (load && store || misalign_s)) begin
                        rdata_out_r   <= 32'h0000_0000;
                        rdata_valid_r <= 1'b1;
                        err_r         <= 1'b1;
                        state_r       <= RESP;
                    end else if (start_s) begin
                        off_r       <= addr[1:0];
                        lanes_r     <= lanes_s;
                        sext_r      <= (op_load_sext == 2'b11) ? 2'b00 : op_load_sext;
                        mem_req_r   <= 1'b1;
                        mem_we_r    <= store;
                        mem_addr_r  <= {addr[31:2], 2'b00};
                        mem_wdata_r <= wdata_sh_s;
                        mem_wstrb_r <= strb_s;
                        cnt_r       <= '0;
                        state_r     <= REQ;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                REQ: begin
                    // Grant takes priority over a timeout expiring in the same cycle.
                    if (mem.mem_gnt) begin
                        mem_req_r <= 1'b0;
                        cnt_r     <= cnt_r + CNT_W'(1);
                        if (mem_we_r) begin
                            rdata_out_r   <= 32'h0000_0000;
                            rdata_valid_r <= 1'b1;
                            state_r       <= RESP;
                        end else begin
                            state_r <= WAIT;
                        end
                    end else if (cnt_r >= CNT_LAST) begin
                        mem_req_r     <= 1'b0;
                        rdata_out_r   <= 32'h0000_0000;
                        rdata_valid_r <= 1'b1;
                        err_r         <= 1'b1;
                        state_r       <= RESP;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                WAIT: begin
                    if (mem.mem_rvalid) begin
                        rdata_out_r   <= load_fmt_s;
                        rdata_valid_r <= 1'b1;
                        state_r       <= RESP;
                    end else if (cnt_r >= CNT_LAST) begin
                        rdata_out_r   <= 32'h0000_0000;
                        rdata_valid_r <= 1'b1;
                        err_r         <= 1'b1;
                        state_r       <= RESP;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                RESP: begin
                    state_r <= IDLE;
                end
                default: begin
                    mem_req_r <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    assign mem.mem_req   = mem_req_r;
    assign mem.mem_we    = mem_we_r;
    assign mem.mem_addr  = mem_addr_r;
    assign mem.mem_wdata = mem_wdata_r;
    assign mem.mem_wstrb = mem_wstrb_r;
    assign rdata_out     = rdata_out_r;
    assign rdata_valid   = rdata_valid_r;
    assign err           = err_r;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed self-checking bench for lsu_mem_ctrl: loads, stores, delays, timeout,
// reset in flight and misaligned accesses.
module tb_lsu_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, valid_to, load, store;
    logic [7:0]  op_PMEM;
    logic [1:0]  op_load_sext;
    logic [31:0] addr, wdata;
    logic        stall, rdata_valid, err;
    logic [31:0] rdata_out;
    logic        stall_to, rdata_valid_to, err_to;
    logic [31:0] rdata_out_to;

    int n_cmp = 0;
    int n_mis = 0;

    int          sc, vc;
    logic [31:0] ro, ma, mwd;
    logic [3:0]  ms;
    logic        e, mwe, rq;

    always #5 clk = ~clk;

    lsu_mem_ctrl_if mi();
    lsu_mem_ctrl_if mt();

    lsu_mem_ctrl dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .load(load), .store(store),
        .op_PMEM(op_PMEM), .op_load_sext(op_load_sext), .addr(addr), .wdata(wdata),
        .stall(stall), .rdata_out(rdata_out), .rdata_valid(rdata_valid), .err(err), .mem(mi)
    );

    lsu_mem_ctrl #(.TIMEOUT(4)) dut_to (
        .clk(clk), .rst(rst), .valid_in(valid_to), .load(load), .store(store),
        .op_PMEM(op_PMEM), .op_load_sext(op_load_sext), .addr(addr), .wdata(wdata),
        .stall(stall_to), .rdata_out(rdata_out_to), .rdata_valid(rdata_valid_to), .err(err_to), .mem(mt)
    );

    // Drive one access on dut and act as memory with the given grant/response delays.
    task automatic do_access(input logic ld, input logic st, input logic [7:0] pm, input logic [1:0] sx,
                             input logic [31:0] a, input logic [31:0] wd, input int gdly, input int rdly,
                             input logic [31:0] rd);
        int  req_cnt = 0;
        int  wait_cnt = 0;
        bit  granted = 1'b0;
        sc = 0; vc = 0; ro = 32'h0; e = 1'b0; rq = 1'b0; ma = 32'h0; mwd = 32'h0; ms = 4'h0; mwe = 1'b0;
        @(negedge clk);
        valid_in = 1'b1; load = ld; store = st; op_PMEM = pm; op_load_sext = sx; addr = a; wdata = wd;
        mi.mem_gnt = 1'b0; mi.mem_rvalid = 1'b0; mi.mem_rdata = 32'h0;
        for (int c = 1; c <= 600; c++) begin
            if (c > 1) @(negedge clk);
            #1;
            if (stall) sc++;
            if (mi.mem_req) begin
                rq = 1'b1; ma = mi.mem_addr; mwd = mi.mem_wdata; ms = mi.mem_wstrb; mwe = mi.mem_we;
            end
            if (rdata_valid) begin
                vc = c; ro = rdata_out; e = err;
                break;
            end
            mi.mem_gnt = 1'b0; mi.mem_rvalid = 1'b0;
            if (mi.mem_req && !granted) begin
                if (req_cnt == gdly) begin mi.mem_gnt = 1'b1; granted = 1'b1; end
                req_cnt++;
            end else if (granted && ld) begin
                if (wait_cnt == rdly) begin mi.mem_rvalid = 1'b1; mi.mem_rdata = rd; end
                wait_cnt++;
            end
        end
        valid_in = 1'b0; load = 1'b0; store = 1'b0; mi.mem_gnt = 1'b0; mi.mem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk); @(negedge clk); #1;
        n_cmp++; if (stall !== 1'b0) begin n_mis++; $display("FAIL rst_stall got=%b exp=0", stall); end
        n_cmp++; if (mi.mem_req !== 1'b0) begin n_mis++; $display("FAIL rst_req got=%b exp=0", mi.mem_req); end
        n_cmp++; if (mi.mem_we !== 1'b0) begin n_mis++; $display("FAIL rst_we got=%b exp=0", mi.mem_we); end
        n_cmp++; if (mi.mem_wstrb !== 4'h0) begin n_mis++; $display("FAIL rst_wstrb got=%h exp=0", mi.mem_wstrb); end
        n_cmp++; if (mi.mem_addr !== 32'h0) begin n_mis++; $display("FAIL rst_addr got=%h exp=0", mi.mem_addr); end
        n_cmp++; if (mi.mem_wdata !== 32'h0) begin n_mis++; $display("FAIL rst_wdata got=%h exp=0", mi.mem_wdata); end
        n_cmp++; if (rdata_out !== 32'h0) begin n_mis++; $display("FAIL rst_rdata got=%h exp=0", rdata_out); end
        n_cmp++; if (rdata_valid !== 1'b0) begin n_mis++; $display("FAIL rst_valid got=%b exp=0", rdata_valid); end
        n_cmp++; if (err !== 1'b0) begin n_mis++; $display("FAIL rst_err got=%b exp=0", err); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_word_load();
        do_access(1'b1, 1'b0, 8'h0F, 2'b00, 32'h8000_0004, 32'h0, 0, 0, 32'hDEAD_BEEF);
        n_cmp++; if (ma !== 32'h8000_0004) begin n_mis++; $display("FAIL wl_addr got=%h exp=80000004", ma); end
        n_cmp++; if (ms !== 4'hF) begin n_mis++; $display("FAIL wl_wstrb got=%h exp=f", ms); end
        n_cmp++; if (mwe !== 1'b0) begin n_mis++; $display("FAIL wl_we got=%b exp=0", mwe); end
        n_cmp++; if (ro !== 32'hDEAD_BEEF) begin n_mis++; $display("FAIL wl_rdata got=%h exp=deadbeef", ro); end
        n_cmp++; if (vc !== 4) begin n_mis++; $display("FAIL wl_valid_cycle got=%0d exp=4", vc); end
        n_cmp++; if (sc !== 3) begin n_mis++; $display("FAIL wl_stall got=%0d exp=3", sc); end
        n_cmp++; if (e !== 1'b0) begin n_mis++; $display("FAIL wl_err got=%b exp=0", e); end
        @(negedge clk); @(negedge clk); #1;
        n_cmp++; if (rdata_out !== 32'hDEAD_BEEF) begin n_mis++; $display("FAIL wl_hold got=%h exp=deadbeef", rdata_out); end
        n_cmp++; if (rdata_valid !== 1'b0) begin n_mis++; $display("FAIL wl_pulse got=%b exp=0", rdata_valid); end
    endtask

    task automatic test_byte_sext();
        do_access(1'b1, 1'b0, 8'h01, 2'b01, 32'h8000_0003, 32'h0, 0, 0, 32'h8011_2233);
        n_cmp++; if (ro !== 32'hFFFF_FF80) begin n_mis++; $display("FAIL sb_sext got=%h exp=ffffff80", ro); end
        n_cmp++; if (ms !== 4'h8) begin n_mis++; $display("FAIL sb_wstrb got=%h exp=8", ms); end
        n_cmp++; if (ma !== 32'h8000_0000) begin n_mis++; $display("FAIL sb_addr got=%h exp=80000000", ma); end
        do_access(1'b1, 1'b0, 8'h01, 2'b00, 32'h8000_0003, 32'h0, 0, 0, 32'h8011_2233);
        n_cmp++; if (ro !== 32'h0000_0080) begin n_mis++; $display("FAIL ub_zext got=%h exp=00000080", ro); end
        do_access(1'b1, 1'b0, 8'h01, 2'b11, 32'h8000_0003, 32'h0, 0, 0, 32'h8011_2233);
        n_cmp++; if (ro !== 32'h0000_0080) begin n_mis++; $display("FAIL sx11_zext got=%h exp=00000080", ro); end
    endtask

    task automatic test_half_store();
        do_access(1'b0, 1'b1, 8'h03, 2'b00, 32'h8000_0002, 32'h0000_ABCD, 0, 0, 32'h0);
        n_cmp++; if (ms !== 4'hC) begin n_mis++; $display("FAIL hs_wstrb got=%h exp=c", ms); end
        n_cmp++; if (mwd !== 32'hABCD_0000) begin n_mis++; $display("FAIL hs_wdata got=%h exp=abcd0000", mwd); end
        n_cmp++; if (mwe !== 1'b1) begin n_mis++; $display("FAIL hs_we got=%b exp=1", mwe); end
        n_cmp++; if (sc !== 2) begin n_mis++; $display("FAIL hs_stall got=%0d exp=2", sc); end
        n_cmp++; if (vc !== 3) begin n_mis++; $display("FAIL hs_valid_cycle got=%0d exp=3", vc); end
        n_cmp++; if (e !== 1'b0) begin n_mis++; $display("FAIL hs_err got=%b exp=0", e); end
        n_cmp++; if (ro !== 32'h0) begin n_mis++; $display("FAIL hs_rdata got=%h exp=0", ro); end
    endtask

    task automatic test_delayed();
        do_access(1'b1, 1'b0, 8'h03, 2'b10, 32'h8000_0002, 32'h0, 5, 3, 32'h8765_1234);
        n_cmp++; if (sc !== 11) begin n_mis++; $display("FAIL dly_stall got=%0d exp=11", sc); end
        n_cmp++; if (vc !== 12) begin n_mis++; $display("FAIL dly_valid_cycle got=%0d exp=12", vc); end
        n_cmp++; if (ro !== 32'hFFFF_8765) begin n_mis++; $display("FAIL dly_rdata got=%h exp=ffff8765", ro); end
    endtask

    task automatic test_misalign();
        do_access(1'b1, 1'b0, 8'h0F, 2'b00, 32'h8000_0001, 32'h0, 0, 0, 32'hAABB_CCDD);
`ifdef LSU_MISALIGN_TRAP_EN
        n_cmp++; if (e !== 1'b1) begin n_mis++; $display("FAIL mis_err got=%b exp=1", e); end
        n_cmp++; if (rq !== 1'b0) begin n_mis++; $display("FAIL mis_req got=%b exp=0", rq); end
        n_cmp++; if (sc !== 1) begin n_mis++; $display("FAIL mis_stall got=%0d exp=1", sc); end
        n_cmp++; if (ro !== 32'h0) begin n_mis++; $display("FAIL mis_rdata got=%h exp=0", ro); end
        do_access(1'b0, 1'b1, 8'h03, 2'b00, 32'h8000_0003, 32'h0000_ABCD, 0, 0, 32'h0);
        n_cmp++; if (e !== 1'b1) begin n_mis++; $display("FAIL mis_hs_err got=%b exp=1", e); end
`else
        n_cmp++; if (ms !== 4'hE) begin n_mis++; $display("FAIL mis_wstrb got=%h exp=e", ms); end
        n_cmp++; if (ro !== 32'h00AA_BBCC) begin n_mis++; $display("FAIL mis_rdata got=%h exp=00aabbcc", ro); end
        n_cmp++; if (e !== 1'b0) begin n_mis++; $display("FAIL mis_err got=%b exp=0", e); end
        do_access(1'b0, 1'b1, 8'h03, 2'b00, 32'h8000_0003, 32'h0000_ABCD, 0, 0, 32'h0);
        n_cmp++; if (ms !== 4'h8) begin n_mis++; $display("FAIL mis_hs_wstrb got=%h exp=8", ms); end
        n_cmp++; if (mwd !== 32'hCD00_0000) begin n_mis++; $display("FAIL mis_hs_wdata got=%h exp=cd000000", mwd); end
`endif
    endtask

    task automatic test_load_store_both();
        do_access(1'b1, 1'b1, 8'h0F, 2'b00, 32'h8000_0008, 32'h1234_5678, 0, 0, 32'h0);
        n_cmp++; if (e !== 1'b1) begin n_mis++; $display("FAIL ls_err got=%b exp=1", e); end
        n_cmp++; if (rq !== 1'b0) begin n_mis++; $display("FAIL ls_req got=%b exp=0", rq); end
        n_cmp++; if (vc !== 2) begin n_mis++; $display("FAIL ls_valid_cycle got=%0d exp=2", vc); end
        n_cmp++; if (ro !== 32'h0) begin n_mis++; $display("FAIL ls_rdata got=%h exp=0", ro); end
    endtask

    task automatic test_timeout();
        int st = 0;
        int rqc = 0;
        int vcy = 0;
        logic [31:0] rot = 32'hFFFF_FFFF;
        logic et = 1'b0;
        @(negedge clk);
        valid_to = 1'b1; load = 1'b1; store = 1'b0; op_PMEM = 8'h0F; op_load_sext = 2'b00; addr = 32'h8000_0020;
        for (int c = 1; c <= 50; c++) begin
            if (c > 1) @(negedge clk);
            #1;
            if (stall_to) st++;
            if (mt.mem_req) rqc++;
            if (rdata_valid_to) begin vcy = c; rot = rdata_out_to; et = err_to; break; end
        end
        valid_to = 1'b0; load = 1'b0;
        n_cmp++; if (rqc !== 4) begin n_mis++; $display("FAIL to_req_cycles got=%0d exp=4", rqc); end
        n_cmp++; if (vcy !== 6) begin n_mis++; $display("FAIL to_valid_cycle got=%0d exp=6", vcy); end
        n_cmp++; if (et !== 1'b1) begin n_mis++; $display("FAIL to_err got=%b exp=1", et); end
        n_cmp++; if (rot !== 32'h0) begin n_mis++; $display("FAIL to_rdata got=%h exp=0", rot); end
        n_cmp++; if (st !== 5) begin n_mis++; $display("FAIL to_stall got=%0d exp=5", st); end
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        valid_in = 1'b1; load = 1'b1; store = 1'b0; op_PMEM = 8'h0F; op_load_sext = 2'b00; addr = 32'h8000_0010;
        mi.mem_gnt = 1'b0; mi.mem_rvalid = 1'b0;
        @(negedge clk); #1;
        n_cmp++; if (mi.mem_req !== 1'b1) begin n_mis++; $display("FAIL rreq_pre got=%b exp=1", mi.mem_req); end
        rst = 1'b1; #1;
        n_cmp++; if (mi.mem_req !== 1'b0) begin n_mis++; $display("FAIL rreq_req got=%b exp=0", mi.mem_req); end
        n_cmp++; if (stall !== 1'b0) begin n_mis++; $display("FAIL rreq_stall got=%b exp=0", stall); end
        @(negedge clk); rst = 1'b0;
        @(negedge clk); #1;
        n_cmp++; if (mi.mem_req !== 1'b1) begin n_mis++; $display("FAIL rwait_relaunch got=%b exp=1", mi.mem_req); end
        mi.mem_gnt = 1'b1;
        @(negedge clk); #1;
        mi.mem_gnt = 1'b0;
        n_cmp++; if (stall !== 1'b1) begin n_mis++; $display("FAIL rwait_pre got=%b exp=1", stall); end
        rst = 1'b1; #1;
        n_cmp++; if (stall !== 1'b0) begin n_mis++; $display("FAIL rwait_stall got=%b exp=0", stall); end
        n_cmp++; if (mi.mem_req !== 1'b0) begin n_mis++; $display("FAIL rwait_req got=%b exp=0", mi.mem_req); end
        valid_in = 1'b0; load = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
    endtask

    // Test sequence.
    initial begin
        rst = 1'b1; valid_in = 1'b0; valid_to = 1'b0; load = 1'b0; store = 1'b0;
        op_PMEM = 8'h00; op_load_sext = 2'b00; addr = 32'h0; wdata = 32'h0;
        mi.mem_gnt = 1'b0; mi.mem_rvalid = 1'b0; mi.mem_rdata = 32'h0;
        mt.mem_gnt = 1'b0; mt.mem_rvalid = 1'b0; mt.mem_rdata = 32'h0;
        test_reset();
        test_word_load();
        test_byte_sext();
        test_half_store();
        test_delayed();
        test_misalign();
        test_load_store_both();
        test_timeout();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

Multi-cycle load/store unit for the NPC core, downstream of the control unit. It takes the decoder's `load`/`store`/`op_PMEM`/`op_load_sext` controls, plus the ALU-computed address and the rs2 store data. It runs one request/grant/response transaction on the data-memory port and returns an aligned, sign-extended load result to the register write-back mux. It holds the core with `stall` while the access is in flight.

## Interface
Parameters:
- `TIMEOUT`, default 255: number of cycles spent in REQ+WAIT before the access is aborted with `err`.

Ports:
- `clk` in 1: core clock.
- `rst` in 1: asynchronous, active-high reset.
- `valid_in` in 1: the instruction currently presented is valid.
- `load` in 1, `store` in 1: decoder access type.
- `op_PMEM` in 8: unshifted lane mask; 8'h01 = byte, 8'h03 = half, 8'h0F = word. Bits [7:4] are ignored.
- `op_load_sext` in 2: 00 = none, 01 = byte sign-extend, 10 = half sign-extend, 11 = treated as 00.
- `addr` in 32: byte address from the ALU.
- `wdata` in 32: store data, right-aligned.
- `stall` out 1: the core holds PC and all inputs stable while this is high.
- `rdata_out` out 32: final load value.
- `rdata_valid` out 1: one-cycle pulse, also asserted for stores.
- `err` out 1: qualifies `rdata_valid`; indicates a timeout or illegal access.
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out 32, `mem_wdata` out 32, `mem_wstrb` out 4: memory request channel.
- `mem_gnt` in 1: request accepted this cycle.
- `mem_rvalid` in 1, `mem_rdata` in 32: read response.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- **IDLE**
  - `valid_in & (load|store)`: capture addr, wdata, op_PMEM, op_load_sext and we=store, then go to REQ.
  - `load & store` both high: no memory access; go to RESP with err=1.
- **REQ**
  - `mem_req`=1. `mem_addr` = {addr[31:2],2'b00}.
  - `mem_wstrb` = (op_PMEM[3:0] << addr[1:0]), truncated to 4 bits.
  - `mem_wdata` = wdata << (8*addr[1:0]).
  - For loads, `mem_wstrb` is the same lane mask and `mem_we`=0.
  - On `mem_gnt`: stores go to RESP, loads go to WAIT.
- **WAIT**
  - On `mem_rvalid`: capture the formatted data and go to RESP.
  - `mem_rvalid` seen while in REQ, or outside WAIT, is ignored.
- **Load formatting**
  - d = mem_rdata >> (8*addr[1:0]).
  - d is masked to the byte or half size.
  - op_load_sext 01 → {{24{d[7]}},d[7:0]}; 10 → {{16{d[15]}},d[15:0]}.
  - Word: d unchanged.
- **RESP**
  - `rdata_valid`=1 for one cycle, then go to IDLE.
  - `rdata_out` holds its value until the next RESP.
  - Stores and errors drive `rdata_out`=0.
- **stall**
  - Combinational: (IDLE & valid_in & (load|store)) | REQ | WAIT.
  - Low in RESP, so the core retires the instruction at the RESP clock edge.
- **Timeout counter**
  - Cleared on entering REQ; counts each cycle in REQ or WAIT.
  - When the count reaches `TIMEOUT` while still in REQ/WAIT: go to RESP with err=1 and `mem_req` dropped.
  - A late response after a timeout is ignored.
- **Non-trapping misalignment**
  - Strobe bits shifted past lane 3 are dropped.
  - Load bytes above lane 3 read as zero before extension.

## Timing
- Reset (async): state=IDLE, `mem_req`=0, `mem_we`=0, `mem_wstrb`=0, `mem_addr`=0, `mem_wdata`=0, `rdata_out`=0, `rdata_valid`=0, `err`=0, counter=0.
  - Reset during REQ/WAIT drops `mem_req` immediately, with no wait for a clock edge.
- All memory-side outputs are registered and stable throughout REQ.
- Minimum load (gnt in first REQ cycle, rvalid the next cycle): stall is high for 3 cycles (IDLE, REQ, WAIT), and `rdata_valid` appears in cycle 4.
- Minimum store: stall is high for 2 cycles, and `rdata_valid` appears in cycle 3.
- Each additional wait cycle on gnt or rvalid adds exactly one stall cycle.
- `mem_gnt` and timeout expiry in the same cycle: the grant wins.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - Misaligned accesses are trapped: a half with addr[0]=1, or a word with addr[1:0]≠0.
  - Such an access issues no `mem_req`; the FSM goes IDLE→RESP with err=1 (stall for 1 cycle).
- Undefined: misaligned accesses are issued with the truncating behaviour described above, and `err` is only raised by timeout or load&store.

## Test plan
- Word load: addr=0x8000_0004, gnt immediate, rdata=0xDEADBEEF → mem_addr=0x8000_0004, wstrb=4'hF, we=0; rdata_out=0xDEADBEEF with the pulse in cycle 4.
- Signed byte load: addr=0x8000_0003, sext=01, rdata=0x80112233 → rdata_out=0xFFFFFF80. The same case with sext=00 → 0x00000080.
- Half store: addr=0x8000_0002, wdata=0x0000ABCD → wstrb=4'hC, mem_wdata=0xABCD0000, we=1; stall for 2 cycles; err=0.
- gnt delayed 5 cycles, then rvalid delayed 3 cycles → stall high for exactly 1+6+4 cycles.
  - Assert rst mid-WAIT → mem_req=0 and stall=0 immediately.
- TIMEOUT=4 with gnt never asserted → err=1, rdata_out=0, and rdata_valid after 4 REQ cycles.
- Word load at addr 0x...01:
  - With the macro defined: err=1 and no mem_req.
  - Without it: wstrb=4'hE and rdata_out=mem_rdata>>8.
